// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - Multicycle RV32I control unit (Moore FSM)
//
// Sequences one instruction over 3-5 cycles and drives the shared-ALU
// datapath. Memory accesses stall on a mem_ready handshake.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   op, funct3, funct7b5    instruction fields from the instruction register
//   zero                    ALU zero flag (branch decision)
//   mem_ready               memory completes the current access this cycle
//   immsrc                  immediate format: 00 I, 01 S, 10 B, 11 J
//   alusrca                 00 PC, 01 OldPC, 10 RD1
//   alusrcb                 00 RD2, 01 ImmExt, 10 constant 4
//   resultsrc               00 ALUOut, 01 Data, 10 ALUResult
//   adrsrc                  memory address: 0 PC, 1 Result
//   alucontrol              000 add, 001 sub, 010 and, 011 or, 101 slt
//   irwrite, pcwrite,
//   regwrite, memwrite      write enables
//   illegal                 one-cycle pulse on an unsupported opcode
module mc_controller (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] immsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] resultsrc,
  output logic       adrsrc,
  output logic [2:0] alucontrol,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       illegal
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_ALUI = 7'b0010011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  state_t state_q;
  state_t state_d;

  // Opcode classification
  logic is_lw, is_alui, is_sw, is_r, is_beq, is_jal, is_legal;

  always_comb begin
    is_lw    = (op == OP_LW);
    is_alui  = (op == OP_ALUI);
    is_sw    = (op == OP_SW);
    is_r     = (op == OP_R);
    is_beq   = (op == OP_BEQ);
    is_jal   = (op == OP_JAL);
    is_legal = is_lw | is_alui | is_sw | is_r | is_beq | is_jal;
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_lw || is_sw)  state_d = S_MEMADR;
        else if (is_r)       state_d = S_EXECUTER;
        else if (is_alui)    state_d = S_EXECUTEI;
        else if (is_jal)     state_d = S_JAL;
        else if (is_beq)     state_d = S_BEQ;
        else                 state_d = S_FETCH;
      end
      S_MEMADR: begin
        // The opcode cannot change here; the FETCH fallback only guards
        // against an instruction register that was disturbed externally.
        if (is_lw)      state_d = S_MEMREAD;
        else if (is_sw) state_d = S_MEMWRITE;
        else            state_d = S_FETCH;
      end
      S_MEMREAD: begin
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: begin
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BEQ:      state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore outputs (raw, before reset gating)
  logic [1:0] aluop;
  logic       pcupdate;
  logic       branch;
  logic       irwrite_raw;
  logic       regwrite_raw;
  logic       memwrite_raw;
  logic       illegal_raw;

  always_comb begin
    alusrca      = 2'b00;
    alusrcb      = 2'b00;
    resultsrc    = 2'b00;
    adrsrc       = 1'b0;
    aluop        = ALUOP_ADD;
    pcupdate     = 1'b0;
    branch       = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    memwrite_raw = 1'b0;
    illegal_raw  = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb     = 2'b10;
        resultsrc   = 2'b10;
        // Only the completing fetch cycle latches the instruction and PC+4.
        irwrite_raw = mem_ready;
        pcupdate    = mem_ready;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut.
        alusrca     = 2'b01;
        alusrcb     = 2'b01;
        illegal_raw = ~is_legal;
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
      end
      S_MEMREAD: begin
        adrsrc = 1'b1;
      end
      S_MEMWB: begin
        resultsrc    = 2'b01;
        regwrite_raw = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc       = 1'b1;
        memwrite_raw = 1'b1;
      end
      S_EXECUTER: begin
        alusrca = 2'b10;
        aluop   = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regwrite_raw = 1'b1;
      end
      S_JAL: begin
        // Jump target comes from ALUOut; ALU forms the link OldPC+4.
        alusrca  = 2'b01;
        alusrcb  = 2'b10;
        pcupdate = 1'b1;
      end
      S_BEQ: begin
        alusrca = 2'b10;
        aluop   = ALUOP_SUB;
        branch  = 1'b1;
      end
      default: begin
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
      end
    endcase
  end

  // ALU decoder
  always_comb begin
    alucontrol = 3'b000;
    case (aluop)
      ALUOP_ADD: alucontrol = 3'b000;
      ALUOP_SUB: alucontrol = 3'b001;
      ALUOP_FUNCT: begin
        case (funct3)
          // op[5] separates R-type sub from I-type addi with imm[10] set.
          3'b000:  alucontrol = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alucontrol = 3'b101;
          3'b110:  alucontrol = 3'b011;
          3'b111:  alucontrol = 3'b010;
          default: alucontrol = 3'b000;
        endcase
      end
      default: alucontrol = 3'b000;
    endcase
  end

  // Immediate format, independent of state
  always_comb begin
    immsrc = 2'b00;
    if (is_sw)       immsrc = 2'b01;
    else if (is_beq) immsrc = 2'b10;
    else if (is_jal) immsrc = 2'b11;
  end

  // Enables are forced low while reset is held, since FETCH with
  // mem_ready high would otherwise assert irwrite/pcwrite.
  always_comb begin
    irwrite  = irwrite_raw & reset_n;
    pcwrite  = (pcupdate | (branch & zero)) & reset_n;
    regwrite = regwrite_raw & reset_n;
    memwrite = memwrite_raw & reset_n;
    illegal  = illegal_raw & reset_n;
  end

endmodule
